// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master: FSM states and mode-bit positions.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: tick is high once every DIV clk cycles, phase restarted by load.
module spi_clk_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with run-time CPOL/CPHA and bit order, compile-time frame length and SCLK divider.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIV    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_W-1:0]         datain,
    input  logic [1:0]                mode,
    input  logic                      lsb_first,
    input  logic                      spi_miso,
    output logic                      spi_cs_l,
    output logic                      spi_sclk,
    output logic                      spi_data,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         dataout,
    output logic [$clog2(DATA_W):0]   counter
);

    localparam int unsigned CW = $clog2(DATA_W) + 1;
    localparam int unsigned EW = $clog2(2 * DATA_W) + 1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    spi_state_e        state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [1:0]        mode_q;
    logic              lsb_q;
    logic [EW-1:0]     edge_cnt;
    logic              tick;
    logic              accept;
    logic              leading;
    logic              last_edge;
    logic              sample_edge;
    logic              drive_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign accept = (state == IDLE) && start;

    spi_clk_div #(.DIV(DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .tick  (tick)
    );

    // edge_cnt holds edges already produced, so an even count means the next edge is leading
    assign leading     = ~edge_cnt[0];
    assign last_edge   = (edge_cnt == LAST_EDGE);
    assign sample_edge = leading ^ mode_q[CPHA_BIT];
    assign drive_edge  = ~sample_edge & ~last_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            spi_cs_l <= 1'b1;
            spi_sclk <= 1'b0;
            spi_data <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            counter  <= '0;
            dataout  <= '0;
            mode_q   <= '0;
            lsb_q    <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LEAD;
                        spi_cs_l <= 1'b0;
                        busy     <= 1'b1;
                        mode_q   <= mode;
                        lsb_q    <= lsb_first;
                        spi_sclk <= mode[CPOL_BIT];
                        edge_cnt <= '0;
                        counter  <= '0;
                        rx_sr    <= '0;
                        if (!mode[CPHA_BIT]) begin
                            spi_data <= first_bit(datain, lsb_first);
                            tx_sr    <= shift_out(datain, lsb_first);
                        end else begin
                            tx_sr    <= datain;
                        end
                    end
                end
                LEAD: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        spi_sclk <= ~spi_sclk;
                        edge_cnt <= edge_cnt + EDGE_ONE;
                        if (sample_edge) begin
                            counter <= counter + CNT_ONE;
                            rx_sr   <= lsb_q ? {spi_miso, rx_sr[DATA_W-1:1]}
                                             : {rx_sr[DATA_W-2:0], spi_miso};
                        end
                        if (drive_edge) begin
                            spi_data <= first_bit(tx_sr, lsb_q);
                            tx_sr    <= shift_out(tx_sr, lsb_q);
                        end
                        if (last_edge) state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state    <= IDLE;
                        spi_cs_l <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        dataout  <= rx_sr;
                        counter  <= '0;
                        spi_data <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: frame-level timing model, SPI slave model, directed frame scenarios.
module tb_spi_master_cfg;

    localparam int W     = 16;
    localparam int DIV0  = 2;
    localparam int FRAME = DIV0 * (2 * W + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // main instance (DIV=2)
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   datain = '0;
    logic [1:0]    mode = '0;
    logic          lsb = 1'b0;
    logic          miso;
    logic          cs_l, sclk, mosi, busy, done;
    logic [15:0]   dataout;
    logic [4:0]    counter;
    logic          loopback = 1'b1;
    logic [15:0]   slave_word = '0;

    // fast instance (DIV=1), loopback only
    logic          start1 = 1'b0;
    logic [15:0]   datain1 = '0;
    logic          cs1, sclk1, mosi1, busy1, done1;
    logic [15:0]   dataout1;
    logic [4:0]    counter1;

    spi_master_cfg #(.DATA_W(W), .DIV(DIV0)) dut (
        .clk(clk), .reset(reset), .start(start), .datain(datain), .mode(mode),
        .lsb_first(lsb), .spi_miso(miso), .spi_cs_l(cs_l), .spi_sclk(sclk),
        .spi_data(mosi), .busy(busy), .done(done), .dataout(dataout), .counter(counter)
    );

    spi_master_cfg #(.DATA_W(W), .DIV(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start1), .datain(datain1), .mode(2'b00),
        .lsb_first(1'b0), .spi_miso(mosi1), .spi_cs_l(cs1), .spi_sclk(sclk1),
        .spi_data(mosi1), .busy(busy1), .done(done1), .dataout(dataout1), .counter(counter1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model: m_f is the cycle index inside the CS-low window, -1 when idle
    int          m_f = -1;
    logic        m_done = 1'b0;
    logic        m_cpol = 1'b0;
    logic [1:0]  m_mode = '0;
    logic        m_lsb = 1'b0;
    logic [15:0] m_rx = '0;
    logic [15:0] m_dataout = '0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_f       <= -1;
            m_done    <= 1'b0;
            m_cpol    <= 1'b0;
            m_mode    <= '0;
            m_dataout <= '0;
        end else if (m_f < 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_f    <= 0;
                m_mode <= mode;
                m_lsb  <= lsb;
                m_cpol <= mode[1];
                m_rx   <= loopback ? datain : slave_word;
            end
        end else if (m_f == FRAME - 1) begin
            m_f       <= -1;
            m_done    <= 1'b1;
            m_dataout <= m_rx;
        end else begin
            m_f <= m_f + 1;
        end
    end

    // Slave model: samples MOSI and drives MISO on the edges the captured mode dictates
    logic        s_prev_cs = 1'b1;
    logic        s_prev_sclk = 1'b0;
    int          s_tx_idx = 0;
    int          s_rx_idx = 0;
    logic [15:0] s_rx_word = '0;
    logic        s_first = 1'b0;
    logic        s_miso = 1'b0;

    function automatic logic bit_at(input logic [15:0] w, input logic lsbf, input int i);
        if (i < 0 || i > 15) return 1'b0;
        return lsbf ? w[i] : w[15 - i];
    endfunction

    assign miso = loopback ? mosi : s_miso;

    always @(negedge clk) begin
        s_prev_cs   <= cs_l;
        s_prev_sclk <= sclk;
        if (s_prev_cs && !cs_l) begin
            s_rx_idx  <= 0;
            s_rx_word <= '0;
            if (!m_mode[0]) begin
                s_miso   <= bit_at(slave_word, m_lsb, 0);
                s_tx_idx <= 1;
            end else begin
                s_tx_idx <= 0;
            end
        end else if (!cs_l && sclk != s_prev_sclk) begin
            if ((sclk != m_cpol) ^ m_mode[0]) begin
                if (s_rx_idx < 16) s_rx_word[m_lsb ? s_rx_idx : 15 - s_rx_idx] <= mosi;
                if (s_rx_idx == 0) s_first <= mosi;
                s_rx_idx <= s_rx_idx + 1;
            end else begin
                s_miso   <= bit_at(slave_word, m_lsb, s_tx_idx);
                s_tx_idx <= s_tx_idx + 1;
            end
        end
    end

    // Per-cycle comparison against the model, plus frame statistics
    int   rise_cnt = 0;
    int   cs_low_cnt = 0;
    int   done_cnt = 0;
    logic mon_prev_sclk = 1'b0;

    always @(negedge clk) begin
        int p, e;
        mon_prev_sclk <= sclk;
        if (!cs_l && sclk && !mon_prev_sclk) rise_cnt <= rise_cnt + 1;
        if (!cs_l) cs_low_cnt <= cs_low_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (chk_en) begin
            if (m_f < 0) begin
                check("cyc_cs_l", cs_l, 1);
                check("cyc_busy", busy, 0);
                check("cyc_counter", counter, 0);
                check("cyc_sclk", sclk, m_cpol);
                check("cyc_done", done, m_done);
                check("cyc_mosi_idle", mosi, 0);
            end else begin
                p = m_f / DIV0;
                e = (p < 1) ? 0 : p - 1;
                if (e > 2 * W) e = 2 * W;
                check("cyc_cs_l", cs_l, 0);
                check("cyc_busy", busy, 1);
                check("cyc_done", done, 0);
                check("cyc_sclk", sclk, m_cpol ^ logic'(e % 2));
                check("cyc_counter", counter, m_mode[0] ? e / 2 : (e + 1) / 2);
            end
            check("cyc_dataout", dataout, m_dataout);
        end
    end

    task automatic wait_done();
        int seen = 0;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_within_budget", seen, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] w, input logic [1:0] md, input logic lsbf,
                             input logic loop, input logic [15:0] sword);
        loopback   = loop;
        slave_word = sword;
        datain     = w;
        mode       = md;
        lsb        = lsbf;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        datain = ~w;
        mode   = ~md;
        wait_done();
    endtask

    int base_rise, base_low, base_done;

    task automatic snap();
        base_rise = rise_cnt;
        base_low  = cs_low_cnt;
        base_done = done_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_cs_l", cs_l, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_counter", counter, 0);
        check("rst_dataout", dataout, 0);
        repeat (2) @(negedge clk);

        // mode 0, MSB first, loopback
        snap();
        run_frame(16'h0412, 2'b00, 1'b0, 1'b1, 16'h0000);
        check("m0_dataout", dataout, 16'h0412);
        check("m0_sclk_rises", rise_cnt - base_rise, 16);
        check("m0_cs_low_cycles", cs_low_cnt - base_low, 68);
        check("m0_done_pulses", done_cnt - base_done, 1);
        check("m0_slave_rx", s_rx_word, 16'h0412);

        // mode 3 against the slave model
        run_frame(16'hABEB, 2'b11, 1'b0, 1'b0, 16'h5A5A);
        check("m3_sclk_idle_high", sclk, 1);
        check("m3_dataout", dataout, 16'h5A5A);
        check("m3_slave_rx_msb_first", s_rx_word, 16'hABEB);
        check("m3_first_mosi", s_first, 1);

        // LSB first
        run_frame(16'h4839, 2'b00, 1'b1, 1'b1, 16'h0000);
        check("lsb_first_mosi", s_first, 1);
        check("lsb_dataout", dataout, 16'h4839);
        check("lsb_slave_rx", s_rx_word, 16'h4839);

        // start pulse mid-frame must be ignored
        snap();
        loopback = 1'b1;
        datain = 16'h1234; mode = 2'b00; lsb = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        datain = 16'hFFFF; mode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("ign_dataout", dataout, 16'h1234);
        check("ign_slave_rx", s_rx_word, 16'h1234);
        check("ign_done_pulses", done_cnt - base_done, 1);
        check("ign_sclk_idle", sclk, 0);

        // reset in the middle of a CPOL=1 frame
        loopback = 1'b1;
        datain = 16'h5555; mode = 2'b10; lsb = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int hit = 0;
            for (int i = 0; i < 200 && hit == 0; i++) begin
                @(negedge clk);
                if (counter == 5'd7) hit = 1;
            end
            check("abort_reached_counter7", hit, 1);
        end
        snap();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_cs_l", cs_l, 1);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_counter", counter, 0);
        check("abort_dataout", dataout, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - base_done, 0);
        run_frame(16'h1234, 2'b00, 1'b0, 1'b1, 16'h0000);
        check("post_abort_dataout", dataout, 16'h1234);

        // back-to-back frames, DIV=1, start held high
        begin
            int dn = 0, low = 0, high = 0, started = 0;
            datain1 = 16'hC3A5;
            start1  = 1'b1;
            for (int cyc = 0; cyc < 300 && dn < 3; cyc++) begin
                @(negedge clk);
                if (!cs1) begin
                    if (started != 0 && high > 0) check("fast_cs_gap", high, 1);
                    low++;
                    high = 0;
                    started = 1;
                end else begin
                    if (low > 0) check("fast_cs_low_cycles", low, 34);
                    low = 0;
                    if (started != 0) begin
                        high++;
                        check("fast_counter_between", counter1, 0);
                    end
                end
                if (done1) begin
                    dn++;
                    check("fast_dataout", dataout1, 16'hC3A5);
                    if (dn == 3) start1 = 1'b0;
                end
            end
            check("fast_done_pulses", dn, 3);
            repeat (4) @(negedge clk);
            check("fast_idle_after", cs1, 1);
            check("fast_busy_after", busy1, 0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
